// File: rtl/fetch_stage_unit.sv
// F stage of the pipeline: owns the PC, drives instruction-memory address and
// forms the F/D bundle; resolves next-PC priority and keeps trace counters.
module fetch_stage_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        M_REQ,
  input  logic        D_is_eret,
  input  logic [31:0] EPC,
  input  logic        D_branch_taken,
  input  logic [31:0] D_npc_target,
  input  logic        D_is_branch_jump,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_instruction,
  output logic [31:0] F_adder,
  output logic [31:0] F_pc,
  output logic        F_rst,
  output logic        F_is_delay,
  output logic [31:0] fetch_cnt,
  output logic [15:0] exc_cnt,
  output logic [1:0]  state
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;
  logic [1:0]  st;
  logic [1:0]  st_nxt;
  logic        adel;
  logic        accept;

  assign pc_plus4 = pc + 32'd4;
  assign adel     = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  // A redirect edge replaces the F/D contents, so it is not an accepted fetch.
  assign accept   = !M_REQ && !stall && !D_is_eret;

  always_comb begin
    pc_nxt = pc_plus4;
    st_nxt = RUN;
    if (M_REQ) begin
      pc_nxt = EXC_ENTRY;
      st_nxt = REDIR;
    end else if (stall) begin
      pc_nxt = pc;
      st_nxt = HOLD;
    end else if (D_is_eret) begin
      pc_nxt = EPC;
      st_nxt = REDIR;
    end else if (D_branch_taken) begin
      pc_nxt = D_npc_target;
      st_nxt = RUN;
    end
    // The spare encoding is never entered; if it is, fall back to RUN.
    if (st == 2'd3)
      st_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      st        <= RUN;
      fetch_cnt <= 32'd0;
      exc_cnt   <= 16'd0;
    end else begin
      pc <= pc_nxt;
      st <= st_nxt;
      if (accept)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (M_REQ && exc_cnt != 16'hFFFF)
        exc_cnt <= exc_cnt + 16'd1;
    end
  end

  assign i_inst_addr   = pc;
  assign F_pc          = pc;
  assign F_adder       = pc_plus4;
  assign F_rst         = adel;
  assign F_instruction = adel ? 32'h0 : i_inst_rdata;
  // Handler entry and eret targets are never delay slots.
  assign F_is_delay    = D_is_branch_jump && (st != REDIR);
  assign state         = st;

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Directed bench for fetch_stage_unit: reset, sequential fetch, stall,
// delayed branch, exception/eret redirects, address-error fetches.
module tb_fetch_stage_unit;
  logic        clk = 1'b0;
  logic        rst, stall, M_REQ, D_is_eret, D_branch_taken, D_is_branch_jump;
  logic [31:0] EPC, D_npc_target, i_inst_rdata, i_inst_addr;
  logic [31:0] F_instruction, F_adder, F_pc, fetch_cnt;
  logic        F_rst, F_is_delay;
  logic [15:0] exc_cnt;
  logic [1:0]  state;
  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;
  // Instruction memory stand-in: word is the bit-inverse of its address.
  assign i_inst_rdata = ~i_inst_addr;

  fetch_stage_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .M_REQ(M_REQ), .D_is_eret(D_is_eret),
    .EPC(EPC), .D_branch_taken(D_branch_taken), .D_npc_target(D_npc_target),
    .D_is_branch_jump(D_is_branch_jump), .i_inst_rdata(i_inst_rdata),
    .i_inst_addr(i_inst_addr), .F_instruction(F_instruction), .F_adder(F_adder),
    .F_pc(F_pc), .F_rst(F_rst), .F_is_delay(F_is_delay), .fetch_cnt(fetch_cnt),
    .exc_cnt(exc_cnt), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; M_REQ = 1'b0; D_is_eret = 1'b0; EPC = 32'h0;
    D_branch_taken = 1'b0; D_npc_target = 32'h0; D_is_branch_jump = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (F_pc !== 32'h3000) $display("FAIL reset_pc got %h exp %h", F_pc, 32'h3000); else pass_cnt++;
    total++; if (F_adder !== 32'h3004) $display("FAIL reset_adder got %h exp %h", F_adder, 32'h3004); else pass_cnt++;
    total++; if (i_inst_addr !== 32'h3000) $display("FAIL reset_iaddr got %h exp %h", i_inst_addr, 32'h3000); else pass_cnt++;
    total++; if (state !== 2'd0) $display("FAIL reset_state got %0d exp 0", state); else pass_cnt++;
    total++; if (fetch_cnt !== 32'd0) $display("FAIL reset_fcnt got %0d exp 0", fetch_cnt); else pass_cnt++;
    total++; if (exc_cnt !== 16'd0) $display("FAIL reset_ecnt got %0d exp 0", exc_cnt); else pass_cnt++;
    total++; if (F_rst !== 1'b0) $display("FAIL reset_frst got %b exp 0", F_rst); else pass_cnt++;
    total++; if (F_instruction !== ~32'h3000) $display("FAIL reset_inst got %h exp %h", F_instruction, ~32'h3000); else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      total++; if (F_pc !== exp_pc) $display("FAIL seq_pc[%0d] got %h exp %h", i, F_pc, exp_pc); else pass_cnt++;
      total++; if (F_adder !== exp_pc + 32'd4) $display("FAIL seq_adder[%0d] got %h exp %h", i, F_adder, exp_pc + 32'd4); else pass_cnt++;
      total++; if (F_rst !== 1'b0) $display("FAIL seq_frst[%0d] got %b exp 0", i, F_rst); else pass_cnt++;
      tick();
      exp_pc = exp_pc + 32'd4;
    end
    total++; if (fetch_cnt !== 32'd4) $display("FAIL seq_fcnt got %0d exp 4", fetch_cnt); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (F_pc !== 32'h3008) $display("FAIL stall_pc[%0d] got %h exp %h", i, F_pc, 32'h3008); else pass_cnt++;
      total++; if (state !== 2'd1) $display("FAIL stall_state[%0d] got %0d exp 1", i, state); else pass_cnt++;
      total++; if (fetch_cnt !== 32'd2) $display("FAIL stall_fcnt[%0d] got %0d exp 2", i, fetch_cnt); else pass_cnt++;
    end
    stall = 1'b0;
    tick();
    total++; if (F_pc !== 32'h300C) $display("FAIL unstall_pc got %h exp %h", F_pc, 32'h300C); else pass_cnt++;
    total++; if (state !== 2'd0) $display("FAIL unstall_state got %0d exp 0", state); else pass_cnt++;
    total++; if (fetch_cnt !== 32'd3) $display("FAIL unstall_fcnt got %0d exp 3", fetch_cnt); else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    D_is_branch_jump = 1'b1; D_branch_taken = 1'b1; D_npc_target = 32'h3100;
    #1;
    total++; if (F_pc !== 32'h3014) $display("FAIL br_slot_pc got %h exp %h", F_pc, 32'h3014); else pass_cnt++;
    total++; if (F_is_delay !== 1'b1) $display("FAIL br_slot_delay got %b exp 1", F_is_delay); else pass_cnt++;
    tick();
    D_is_branch_jump = 1'b0; D_branch_taken = 1'b0;
    #1;
    total++; if (F_pc !== 32'h3100) $display("FAIL br_target_pc got %h exp %h", F_pc, 32'h3100); else pass_cnt++;
    total++; if (F_is_delay !== 1'b0) $display("FAIL br_target_delay got %b exp 0", F_is_delay); else pass_cnt++;
    total++; if (fetch_cnt !== 32'd6) $display("FAIL br_fcnt got %0d exp 6", fetch_cnt); else pass_cnt++;
  endtask

  task automatic test_exc_eret();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    total++; if (F_pc !== 32'h3020) $display("FAIL exc_pre_pc got %h exp %h", F_pc, 32'h3020); else pass_cnt++;
    M_REQ = 1'b1; stall = 1'b1; D_is_branch_jump = 1'b1;
    tick();
    M_REQ = 1'b0; stall = 1'b0;
    #1;
    total++; if (F_pc !== 32'h4180) $display("FAIL exc_pc got %h exp %h", F_pc, 32'h4180); else pass_cnt++;
    total++; if (exc_cnt !== 16'd1) $display("FAIL exc_cnt got %0d exp 1", exc_cnt); else pass_cnt++;
    total++; if (state !== 2'd2) $display("FAIL exc_state got %0d exp 2", state); else pass_cnt++;
    total++; if (F_is_delay !== 1'b0) $display("FAIL exc_delay got %b exp 0", F_is_delay); else pass_cnt++;
    total++; if (fetch_cnt !== 32'd8) $display("FAIL exc_fcnt got %0d exp 8", fetch_cnt); else pass_cnt++;
    D_is_eret = 1'b1; EPC = 32'h3024; D_is_branch_jump = 1'b0;
    tick();
    D_is_eret = 1'b0; D_is_branch_jump = 1'b1;
    #1;
    total++; if (F_pc !== 32'h3024) $display("FAIL eret_pc got %h exp %h", F_pc, 32'h3024); else pass_cnt++;
    total++; if (state !== 2'd2) $display("FAIL eret_state got %0d exp 2", state); else pass_cnt++;
    total++; if (F_is_delay !== 1'b0) $display("FAIL eret_delay got %b exp 0", F_is_delay); else pass_cnt++;
    total++; if (fetch_cnt !== 32'd8) $display("FAIL eret_fcnt got %0d exp 8", fetch_cnt); else pass_cnt++;
    tick();
    total++; if (F_pc !== 32'h3028) $display("FAIL post_eret_pc got %h exp %h", F_pc, 32'h3028); else pass_cnt++;
    total++; if (state !== 2'd0) $display("FAIL post_eret_state got %0d exp 0", state); else pass_cnt++;
    total++; if (F_is_delay !== 1'b1) $display("FAIL post_eret_delay got %b exp 1", F_is_delay); else pass_cnt++;
    total++; if (fetch_cnt !== 32'd9) $display("FAIL post_eret_fcnt got %0d exp 9", fetch_cnt); else pass_cnt++;
    D_is_branch_jump = 1'b0;
  endtask

  task automatic test_fetch_exc();
    logic [31:0] tgt [5] = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC, 32'h3000};
    logic        bad [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      D_branch_taken = 1'b1; D_npc_target = tgt[i];
      tick();
      D_branch_taken = 1'b0;
      #1;
      total++; if (F_pc !== tgt[i]) $display("FAIL adel_pc[%0d] got %h exp %h", i, F_pc, tgt[i]); else pass_cnt++;
      total++; if (F_rst !== bad[i]) $display("FAIL adel_frst[%0d] got %b exp %b", i, F_rst, bad[i]); else pass_cnt++;
      total++; if (F_instruction !== (bad[i] ? 32'h0 : ~tgt[i])) $display("FAIL adel_inst[%0d] got %h exp %h", i, F_instruction, bad[i] ? 32'h0 : ~tgt[i]); else pass_cnt++;
      total++; if (F_adder !== tgt[i] + 32'd4) $display("FAIL adel_adder[%0d] got %h exp %h", i, F_adder, tgt[i] + 32'd4); else pass_cnt++;
      total++; if (i_inst_addr !== tgt[i]) $display("FAIL adel_iaddr[%0d] got %h exp %h", i, i_inst_addr, tgt[i]); else pass_cnt++;
    end
    D_branch_taken = 1'b1; D_npc_target = 32'h7000;
    tick();
    D_branch_taken = 1'b0;
    M_REQ = 1'b1;
    tick();
    M_REQ = 1'b0;
    #1;
    total++; if (F_pc !== 32'h4180) $display("FAIL adel_exc_pc got %h exp %h", F_pc, 32'h4180); else pass_cnt++;
    total++; if (F_rst !== 1'b0) $display("FAIL adel_exc_frst got %b exp 0", F_rst); else pass_cnt++;
    total++; if (exc_cnt !== 16'd2) $display("FAIL adel_exc_cnt got %0d exp 2", exc_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap();
    D_branch_taken = 1'b1; D_npc_target = 32'hFFFF_FFFC;
    tick();
    D_branch_taken = 1'b0;
    #1;
    total++; if (F_adder !== 32'h0) $display("FAIL wrap_adder got %h exp 0", F_adder); else pass_cnt++;
    tick();
    total++; if (F_pc !== 32'h0) $display("FAIL wrap_pc got %h exp 0", F_pc); else pass_cnt++;
    total++; if (F_rst !== 1'b1) $display("FAIL wrap_frst got %b exp 1", F_rst); else pass_cnt++;
  endtask

  task automatic test_rst_mid_stall();
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    #1;
    total++; if (F_pc !== 32'h3000) $display("FAIL rst_stall_pc got %h exp %h", F_pc, 32'h3000); else pass_cnt++;
    total++; if (fetch_cnt !== 32'd0) $display("FAIL rst_stall_fcnt got %0d exp 0", fetch_cnt); else pass_cnt++;
    total++; if (exc_cnt !== 16'd0) $display("FAIL rst_stall_ecnt got %0d exp 0", exc_cnt); else pass_cnt++;
    total++; if (state !== 2'd0) $display("FAIL rst_stall_state got %0d exp 0", state); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_exc_eret();
    test_fetch_exc();
    test_wrap();
    test_rst_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
